// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_pkg
// Brief   : Opcode, bus-size and FSM encodings plus decode helpers for mem_lsu.
// Revision: 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  localparam int GPR_BUS      = 32;
  localparam int GPR_ADDR_BUS = 5;
  localparam int MEM_OP_BUS   = 4;

  typedef enum logic [MEM_OP_BUS-1:0] {
    MEM_OP_NOP = 4'd0,
    MEM_OP_LB  = 4'd1,
    MEM_OP_LBU = 4'd2,
    MEM_OP_LH  = 4'd3,
    MEM_OP_LHU = 4'd4,
    MEM_OP_LW  = 4'd5,
    MEM_OP_SB  = 4'd6,
    MEM_OP_SH  = 4'd7,
    MEM_OP_SW  = 4'd8
  } mem_op_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic op_is_load(input logic [MEM_OP_BUS-1:0] op);
    op_is_load = (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_BUS-1:0] op);
    op_is_store = (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [MEM_OP_BUS-1:0] op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: op_size = SIZE_BYTE;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: op_size = SIZE_HALF;
      default:                          op_size = SIZE_WORD;
    endcase
  endfunction

  // Only memory ops can fault; non-memory ops decode as word size.
  function automatic logic op_misaligned(input logic [MEM_OP_BUS-1:0] op,
                                         input logic [1:0]            a);
    op_misaligned = 1'b0;
    if (op_is_load(op) || op_is_store(op)) begin
      case (op_size(op))
        SIZE_HALF: op_misaligned = a[0];
        SIZE_WORD: op_misaligned = (a != 2'b00);
        default:   op_misaligned = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [GPR_BUS-1:0] store_format(input logic [MEM_OP_BUS-1:0] op,
                                                      input logic [GPR_BUS-1:0]    d);
    case (op_size(op))
      SIZE_BYTE: store_format = {4{d[7:0]}};
      SIZE_HALF: store_format = {2{d[15:0]}};
      default:   store_format = d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_load_extend
// Brief   : Little-endian lane select and sign/zero extension of load data.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lsu_load_extend
  import mem_lsu_pkg::*;
(
  input  logic [MEM_OP_BUS-1:0] op_i,
  input  logic [1:0]            addr_i,
  input  logic [GPR_BUS-1:0]    rdata_i,
  output logic [GPR_BUS-1:0]    result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      MEM_OP_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: result_o = {24'h0, byte_sel};
      MEM_OP_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: result_o = {16'h0, half_sel};
      default:    result_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu
// Brief   : MEM-stage load/store unit: sram-like bus sequencing, load extension,
//           store lane replication and address-error detection.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [MEM_OP_BUS-1:0]   ex_mem_op,
  input  logic [GPR_BUS-1:0]      ex_addr,
  input  logic [GPR_BUS-1:0]      ex_store_data,
  input  logic                    ex_regfile_write_enable,
  input  logic [GPR_ADDR_BUS-1:0] ex_regfile_write_addr,
  input  logic [GPR_BUS-1:0]      ex_regfile_write_data,
  input  logic [GPR_BUS-1:0]      ex_pc,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [1:0]              data_size,
  output logic [GPR_BUS-1:0]      data_addr,
  output logic [GPR_BUS-1:0]      data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic [GPR_BUS-1:0]      data_rdata,
  output logic                    mem_regfile_write_enable,
  output logic [GPR_ADDR_BUS-1:0] mem_regfile_write_addr,
  output logic [GPR_BUS-1:0]      mem_regfile_write_data,
  output logic [GPR_BUS-1:0]      mem_pc,
  output logic                    stall_req,
  output logic                    exc_adel,
  output logic                    exc_ades,
  output logic [GPR_BUS-1:0]      bad_vaddr
);

  lsu_state_e state_q, state_d;

  logic [GPR_BUS-1:0]      addr_q, wdata_q, exdata_q, pc_q, rdata_q;
  logic [1:0]              size_q;
  logic                    wr_q, we_q;
  logic [MEM_OP_BUS-1:0]   op_q;
  logic [GPR_ADDR_BUS-1:0] dest_q;

  logic [GPR_BUS-1:0] load_ext;
  logic               latch_en, capture_en;
  logic               is_load, is_store, misaligned, new_mem_op;

  assign is_load    = op_is_load(ex_mem_op);
  assign is_store   = op_is_store(ex_mem_op);
  assign misaligned = op_misaligned(ex_mem_op, ex_addr[1:0]);
  assign new_mem_op = (is_load || is_store) && !misaligned;

  mem_lsu_load_extend u_load_extend (
    .op_i     (op_q),
    .addr_i   (addr_q[1:0]),
    .rdata_i  (data_rdata),
    .result_o (load_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      exdata_q <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      we_q     <= 1'b0;
      op_q     <= '0;
      dest_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q   <= ex_addr;
        size_q   <= op_size(ex_mem_op);
        wr_q     <= is_store;
        wdata_q  <= store_format(ex_mem_op, ex_store_data);
        op_q     <= ex_mem_op;
        dest_q   <= ex_regfile_write_addr;
        we_q     <= ex_regfile_write_enable && is_load;
        exdata_q <= ex_regfile_write_data;
        pc_q     <= ex_pc;
      end
      if (capture_en) begin
        rdata_q <= load_ext;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;

    data_req   = 1'b0;
    data_wr    = wr_q;
    data_size  = size_q;
    data_addr  = addr_q;
    data_wdata = wdata_q;

    mem_regfile_write_enable = ex_regfile_write_enable && !misaligned;
    mem_regfile_write_addr   = ex_regfile_write_addr;
    mem_regfile_write_data   = ex_regfile_write_data;
    mem_pc                   = ex_pc;
    stall_req                = 1'b0;

    exc_adel  = is_load && misaligned;
    exc_ades  = is_store && misaligned;
    bad_vaddr = misaligned ? ex_addr : '0;

    case (state_q)
      ST_IDLE: begin
        if (new_mem_op && !flush) begin
          latch_en  = 1'b1;
          stall_req = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        data_req                 = 1'b1;
        stall_req                = 1'b1;
        mem_regfile_write_enable = 1'b0;
        if (data_addr_ok) begin
          state_d = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_req                = 1'b1;
        mem_regfile_write_enable = 1'b0;
        if (data_data_ok) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            capture_en = 1'b1;
            state_d    = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_RESP: begin
        mem_regfile_write_enable = we_q;
        mem_regfile_write_addr   = dest_q;
        mem_regfile_write_data   = wr_q ? exdata_q : rdata_q;
        mem_pc                   = pc_q;
        state_d                  = ST_IDLE;
      end
      ST_DRAIN: begin
        // A killed transfer still owes one response; hold any new memory op until it lands.
        if (new_mem_op) begin
          stall_req                = 1'b1;
          mem_regfile_write_enable = 1'b0;
        end
        if (data_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst) begin
      data_req                 = 1'b0;
      data_wr                  = 1'b0;
      data_size                = '0;
      data_addr                = '0;
      data_wdata               = '0;
      mem_regfile_write_enable = 1'b0;
      mem_regfile_write_addr   = '0;
      mem_regfile_write_data   = '0;
      mem_pc                   = '0;
      stall_req                = 1'b0;
      exc_adel                 = 1'b0;
      exc_ades                 = 1'b0;
      bad_vaddr                = '0;
    end
  end

endmodule
`default_nettype wire
